// File: rtl/csr_mem_responder.sv
// Two-bank memory responder: host preload port plus two independent read
// ports, each with a fixed pipelined latency and a saturating request counter.

module csr_mem_port #(
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 32,
  parameter int                DEPTH        = 512,
  parameter int                LATENCY      = 2,
  parameter logic [ADDR_W-1:0] BASE         = '0,
  parameter logic [DATA_W-1:0] DEFAULT_DATA = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o,
  output logic [15:0]       rdcnt_o
);

  localparam int IDX_W = $clog2(DEPTH);
  // One bit wider so a window ending at the top of the address space cannot wrap.
  localparam logic [ADDR_W:0] END_ADDR = {1'b0, BASE} + (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] ram_q;
  logic              rd_hit, wr_hit, acc;
  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic              v1_q, err1_q, seen_q;
  logic [DATA_W-1:0] dat1;
  logic [15:0]       cnt_q, cnt_d;

  assign rd_hit = (addr_i >= BASE) && ({1'b0, addr_i} < END_ADDR);
  assign wr_hit = (waddr_i >= BASE) && ({1'b0, waddr_i} < END_ADDR);
  assign rd_idx = IDX_W'(addr_i - BASE);
  assign wr_idx = IDX_W'(waddr_i - BASE);
  assign acc    = req_i && !rst_i;

  // Read and write in one process so a same-index read returns the old word.
  always_ff @(posedge clk_i) begin
    if (we_i && !rst_i && wr_hit) mem_q[wr_idx] <= wdata_i;
    if (acc && rd_hit) ram_q <= mem_q[rd_idx];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q   <= 1'b0;
      err1_q <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      v1_q <= req_i;
      if (req_i) begin
        err1_q <= !rd_hit;
        seen_q <= 1'b1;
      end
    end
  end

  // RAM output register has no reset; seen_q forces zero until the first read.
  assign dat1 = !seen_q ? '0 : (err1_q ? DEFAULT_DATA : ram_q);

  generate
    if (LATENCY == 1) begin : g_lat1
      assign valid_o = v1_q;
      assign err_o   = v1_q && err1_q;
      assign data_o  = dat1;
    end else begin : g_pipe
      logic [LATENCY-1:1] vld_q, err_q;
      logic [DATA_W-1:0]  dat_q [1:LATENCY-1];

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          vld_q <= '0;
          err_q <= '0;
          for (int k = 1; k < LATENCY; k++) dat_q[k] <= '0;
        end else begin
          vld_q[1] <= v1_q;
          if (v1_q) begin
            err_q[1] <= err1_q;
            dat_q[1] <= dat1;
          end
          for (int k = 2; k < LATENCY; k++) begin
            vld_q[k] <= vld_q[k-1];
            if (vld_q[k-1]) begin
              err_q[k] <= err_q[k-1];
              dat_q[k] <= dat_q[k-1];
            end
          end
        end
      end

      assign valid_o = vld_q[LATENCY-1];
      assign err_o   = vld_q[LATENCY-1] && err_q[LATENCY-1];
      assign data_o  = dat_q[LATENCY-1];
    end
  endgenerate

  assign cnt_d = (acc && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign rdcnt_o = cnt_q;

endmodule

module csr_mem_responder #(
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 32,
  parameter int                DEPTH        = 512,
  parameter logic [ADDR_W-1:0] A_BASE       = ADDR_W'(2950),
  parameter logic [ADDR_W-1:0] B_BASE       = ADDR_W'(0),
  parameter int                LATENCY      = 2,
  parameter logic [DATA_W-1:0] DEFAULT_DATA = DATA_W'(99999)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              WR,
  input  logic              wsel,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              reqA,
  input  logic [ADDR_W-1:0] addrA,
  output logic              validA,
  output logic [DATA_W-1:0] dataA,
  output logic              errA,
  input  logic              reqB,
  input  logic [ADDR_W-1:0] addrB,
  output logic              validB,
  output logic [DATA_W-1:0] dataB,
  output logic              errB,
  output logic [15:0]       rdcntA,
  output logic [15:0]       rdcntB
);

  generate
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("csr_mem_responder: LATENCY must be in 1..4");
    end
  endgenerate

  csr_mem_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LATENCY),
    .BASE(A_BASE), .DEFAULT_DATA(DEFAULT_DATA)
  ) u_port_a (
    .clk_i(Clk), .rst_i(Rst), .we_i(WR && !wsel), .waddr_i(waddr), .wdata_i(wdata),
    .req_i(reqA), .addr_i(addrA), .valid_o(validA), .data_o(dataA), .err_o(errA),
    .rdcnt_o(rdcntA)
  );

  csr_mem_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LATENCY),
    .BASE(B_BASE), .DEFAULT_DATA(DEFAULT_DATA)
  ) u_port_b (
    .clk_i(Clk), .rst_i(Rst), .we_i(WR && wsel), .waddr_i(waddr), .wdata_i(wdata),
    .req_i(reqB), .addr_i(addrB), .valid_o(validB), .data_o(dataB), .err_o(errB),
    .rdcnt_o(rdcntB)
  );

endmodule

// File: tb/tb_csr_mem_responder.sv
// Directed bench for csr_mem_responder: reference memory model, per-port
// expected-response queues and a negedge monitor that pops and compares.

module tb_csr_mem_responder;
  localparam int L = 2;
  localparam logic [31:0] ABASE = 32'd2950;
  localparam logic [31:0] BBASE = 32'd0;
  localparam logic [31:0] DEF   = 32'd99999;

  logic        Clk = 1'b0;
  logic        Rst, WR, wsel, reqA, reqB;
  logic [31:0] waddr, wdata, addrA, addrB;
  logic        validA, validB, errA, errB;
  logic [31:0] dataA, dataB;
  logic [15:0] rdcntA, rdcntB;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          due;
  } exp_t;

  exp_t        qa[$], qb[$];
  exp_t        ea, eb, tmp;
  logic [31:0] ma [512];
  logic [31:0] mb [512];
  int          cnta = 0, cntb = 0;
  int          checks = 0, errors = 0, cyc = 0;

  csr_mem_responder dut (
    .Clk(Clk), .Rst(Rst), .WR(WR), .wsel(wsel), .waddr(waddr), .wdata(wdata),
    .reqA(reqA), .addrA(addrA), .validA(validA), .dataA(dataA), .errA(errA),
    .reqB(reqB), .addrB(addrB), .validB(validB), .dataB(dataB), .errB(errB),
    .rdcntA(rdcntA), .rdcntB(rdcntB)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic hit(input logic [31:0] a, input logic [31:0] base);
    return (a >= base) && (a < base + 32'd512);
  endfunction

  function automatic int sat(input int c);
    return (c == 65535) ? 65535 : c + 1;
  endfunction

  // Drive one cycle of stimulus and record what the DUT owes us for it.
  task automatic step(input logic ra, input logic [31:0] aa, input logic rb, input logic [31:0] ab,
                      input logic w, input logic ws, input logic [31:0] wa, input logic [31:0] wd);
    reqA = ra; addrA = aa; reqB = rb; addrB = ab;
    WR = w; wsel = ws; waddr = wa; wdata = wd;
    if (Rst) begin
      while (qa.size() != 0 && qa[$].due > cyc) tmp = qa.pop_back();
      while (qb.size() != 0 && qb[$].due > cyc) tmp = qb.pop_back();
      cnta = 0;
      cntb = 0;
    end else begin
      if (ra) begin
        tmp.due = cyc + L;
        if (hit(aa, ABASE)) begin tmp.d = ma[aa - ABASE]; tmp.e = 1'b0; end
        else begin tmp.d = DEF; tmp.e = 1'b1; end
        qa.push_back(tmp);
        cnta = sat(cnta);
      end
      if (rb) begin
        tmp.due = cyc + L;
        if (hit(ab, BBASE)) begin tmp.d = mb[ab - BBASE]; tmp.e = 1'b0; end
        else begin tmp.d = DEF; tmp.e = 1'b1; end
        qb.push_back(tmp);
        cntb = sat(cntb);
      end
      if (w) begin
        if (!ws && hit(wa, ABASE)) ma[wa - ABASE] = wd;
        if (ws && hit(wa, BBASE))  mb[wa - BBASE] = wd;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge Clk) begin
    if (validA === 1'b1) begin
      chk("A_unexpected_valid", qa.size() != 0, 1);
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        chk("A_data", dataA, ea.d);
        chk("A_err", errA, ea.e);
        chk("A_time", cyc, ea.due);
      end
    end else begin
      chk("A_err_idle", errA, 0);
    end
    if (validB === 1'b1) begin
      chk("B_unexpected_valid", qb.size() != 0, 1);
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        chk("B_data", dataB, eb.d);
        chk("B_err", errB, eb.e);
        chk("B_time", cyc, eb.due);
      end
    end else begin
      chk("B_err_idle", errB, 0);
    end
  end

  initial begin
    Rst = 1'b1; WR = 0; wsel = 0; waddr = 0; wdata = 0;
    reqA = 0; addrA = 0; reqB = 0; addrB = 0;
    idle(2);
    Rst = 1'b0;
    chk("rst_validA", validA, 0);
    chk("rst_validB", validB, 0);
    chk("rst_dataA", dataA, 0);
    chk("rst_dataB", dataB, 0);
    chk("rst_rdcntA", rdcntA, 0);
    chk("rst_rdcntB", rdcntB, 0);

    // Preload: A window edges, B entries, and stray writes that must be dropped.
    step(0, 0, 0, 0, 1, 0, 2950, 0);
    step(0, 0, 0, 0, 1, 0, 2951, 13);
    step(0, 0, 0, 0, 1, 0, 2952, 28);
    step(0, 0, 0, 0, 1, 0, 3461, 555);
    step(0, 0, 0, 0, 1, 1, 2, 82);
    step(0, 0, 0, 0, 1, 1, 90, 31);
    step(0, 0, 0, 0, 1, 1, 511, 4242);
    step(0, 0, 0, 0, 1, 0, 90, 32'hBAD0);
    step(0, 0, 0, 0, 1, 1, 512, 32'hBAD1);

    // Back-to-back A reads
    step(1, 2950, 0, 0, 0, 0, 0, 0);
    step(1, 2951, 0, 0, 0, 0, 0, 0);
    step(1, 2952, 0, 0, 0, 0, 0, 0);
    idle(3);
    chk("rdcntA_after3", rdcntA, 16'd3);

    // Window boundaries on A
    step(1, 2949, 0, 0, 0, 0, 0, 0);
    step(1, 3462, 0, 0, 0, 0, 0, 0);
    step(1, 3461, 0, 0, 0, 0, 0, 0);
    idle(3);
    chk("rdcntA_after_miss", rdcntA, cnta[15:0]);

    // Read-before-write on B, then read-after-write; B edges and the stray A write
    step(0, 0, 1, 90, 1, 1, 90, 77);
    step(0, 0, 1, 90, 0, 0, 0, 0);
    step(0, 0, 1, 511, 0, 0, 0, 0);
    step(0, 0, 1, 512, 0, 0, 0, 0);
    idle(3);
    chk("rdcntB_after", rdcntB, cntb[15:0]);

    // Concurrent A/B streams with a simultaneous write to an unrelated location
    for (int i = 0; i < 10; i++) step(1, 2951, 1, 2, (i == 4), 1, 300, 32'h1234);
    idle(3);
    chk("rdcntA_conc", rdcntA, cnta[15:0]);
    chk("rdcntB_conc", rdcntB, cntb[15:0]);

    // Reset while reads are in flight; the reset-cycle write must be ignored
    step(1, 2950, 0, 0, 0, 0, 0, 0);
    Rst = 1'b1;
    step(1, 2951, 1, 2, 1, 0, 2950, 32'hDEAD);
    Rst = 1'b0;
    chk("rdcntA_post_rst", rdcntA, 16'd0);
    chk("rdcntB_post_rst", rdcntB, 16'd0);
    idle(4);
    chk("qA_flushed", qa.size(), 0);
    step(1, 2950, 0, 0, 0, 0, 0, 0);
    idle(3);
    chk("rdcntA_reread", rdcntA, 16'd1);

    // Counter saturation
    for (int i = 0; i < 65540; i++) step(1, 2950, 0, 0, 0, 0, 0, 0);
    chk("rdcntA_sat", rdcntA, 16'hFFFF);
    step(1, 2951, 0, 0, 0, 0, 0, 0);
    step(1, 2952, 0, 0, 0, 0, 0, 0);
    idle(4);
    chk("rdcntA_sat_hold", rdcntA, 16'hFFFF);
    chk("rdcntA_model", rdcntA, cnta[15:0]);

    chk("qA_drained", qa.size(), 0);
    chk("qB_drained", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
